// File: rtl/led_mode_sequencer_pkg.sv
// Shared constants, types and helpers for the LED mode sequencer front end.
package led_mode_sequencer_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned MAX_W  = 8;
  localparam int unsigned WIDE_W = MAX_W + 1;

  typedef logic [MODE_W-1:0] mode_t;
  typedef logic [MAX_W-1:0]  max_t;
  typedef logic [WIDE_W-1:0] wide_t;

  // Direction select encoding presented to the LED block as {s1,s0}.
  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_RIGHT  = 2'b01;
  localparam mode_t MODE_LEFT   = 2'b10;
  localparam mode_t MODE_BOUNCE = 2'b11;

  localparam mode_t MODE_RESET = MODE_LEFT;
  localparam max_t  MAX_LIMIT  = 8'd255;

  // Controller ownership of the mode output.
  typedef enum logic {
    CTRL_MANUAL = 1'b0,
    CTRL_AUTO   = 1'b1
  } ctrl_state_t;

  // One-cycle press pulses from the four push-buttons.
  typedef struct packed {
    logic mode;
    logic pause;
    logic faster;
    logic slower;
  } press_t;

  // Manual sequence: LEFT -> RIGHT -> BOUNCE -> HOLD -> LEFT.
  function automatic mode_t next_manual_mode(input mode_t cur);
    mode_t nxt;
    nxt = MODE_LEFT;
    case (cur)
      MODE_LEFT:   nxt = MODE_RIGHT;
      MODE_RIGHT:  nxt = MODE_BOUNCE;
      MODE_BOUNCE: nxt = MODE_HOLD;
      MODE_HOLD:   nxt = MODE_LEFT;
      default:     nxt = MODE_LEFT;
    endcase
    return nxt;
  endfunction

  // Auto-cycling alternates between LEFT and RIGHT only.
  function automatic mode_t next_auto_mode(input mode_t cur);
    return (cur == MODE_LEFT) ? MODE_RIGHT : MODE_LEFT;
  endfunction

  // Saturating decrement, computed one bit wider so it never wraps.
  function automatic max_t sat_dec(input max_t cur, input wide_t step);
    wide_t cur_w;
    wide_t res_w;
    cur_w = {1'b0, cur};
    res_w = (cur_w < step) ? '0 : (cur_w - step);
    return res_w[MAX_W-1:0];
  endfunction

  // Saturating increment clamped at MAX_LIMIT.
  function automatic max_t sat_inc(input max_t cur, input wide_t step);
    wide_t cur_w;
    wide_t res_w;
    cur_w = {1'b0, cur};
    res_w = cur_w + step;
    if (res_w > {1'b0, MAX_LIMIT}) begin
      res_w = {1'b0, MAX_LIMIT};
    end
    return res_w[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer with a rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_q2;
          press <= sync_q2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// Board-side controller producing direction, pause and speed limit for the LED block.
module led_mode_sequencer
  import led_mode_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_DWELL      = 50000000,
  parameter int unsigned MAX_STEP        = 16,
  parameter int unsigned MAX_INIT        = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_pause,
  input  logic       btn_faster,
  input  logic       btn_slower,
  input  logic       auto_en,
  output logic       s1,
  output logic       s0,
  output logic       pause,
  output logic [7:0] max,
  output logic       auto_active
);

  localparam int unsigned DWELL_W    = (AUTO_DWELL > 1) ? $clog2(AUTO_DWELL) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTO_DWELL - 1);
  localparam wide_t STEP_W    = WIDE_W'(MAX_STEP);
  localparam max_t  MAX_RESET = MAX_W'(MAX_INIT);

  press_t             presses;
  logic               auto_level;
  logic [3:0]         btn_level_unused;
  logic               auto_press_unused;

  ctrl_state_t        state;
  mode_t              mode;
  logic [DWELL_W-1:0] dwell;
  max_t               max_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk    (clk),
    .rst    (rst),
    .raw_in (btn_mode),
    .level  (btn_level_unused[0]),
    .press  (presses.mode)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk    (clk),
    .rst    (rst),
    .raw_in (btn_pause),
    .level  (btn_level_unused[1]),
    .press  (presses.pause)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_faster (
    .clk    (clk),
    .rst    (rst),
    .raw_in (btn_faster),
    .level  (btn_level_unused[2]),
    .press  (presses.faster)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_slower (
    .clk    (clk),
    .rst    (rst),
    .raw_in (btn_slower),
    .level  (btn_level_unused[3]),
    .press  (presses.slower)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_auto (
    .clk    (clk),
    .rst    (rst),
    .raw_in (auto_en),
    .level  (auto_level),
    .press  (auto_press_unused)
  );

  // Next speed limit; simultaneous faster and slower cancel out.
  always_comb begin
    max_next = max;
    case ({presses.faster, presses.slower})
      2'b10:   max_next = sat_dec(max, STEP_W);
      2'b01:   max_next = sat_inc(max, STEP_W);
      default: max_next = max;
    endcase
  end

  // Mode FSM with pause toggle, speed register and auto-cycling dwell timer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= CTRL_MANUAL;
      mode        <= MODE_RESET;
      dwell       <= '0;
      pause       <= 1'b1;
      max         <= MAX_RESET;
      auto_active <= 1'b0;
    end else begin
      if (presses.pause) begin
        pause <= ~pause;
      end
      max <= max_next;

      case (state)
        CTRL_MANUAL: begin
          if (auto_level) begin
            state       <= CTRL_AUTO;
            auto_active <= 1'b1;
            mode        <= MODE_LEFT;
            dwell       <= '0;
          end else if (presses.mode) begin
            mode <= next_manual_mode(mode);
          end
        end
        CTRL_AUTO: begin
          if (!auto_level) begin
            // Leaving auto keeps whatever direction was showing.
            state       <= CTRL_MANUAL;
            auto_active <= 1'b0;
          end else if (!pause) begin
            if (dwell == DWELL_LAST) begin
              mode  <= next_auto_mode(mode);
              dwell <= '0;
            end else begin
              dwell <= dwell + DWELL_W'(1);
            end
          end
        end
        default: begin
          state       <= CTRL_MANUAL;
          auto_active <= 1'b0;
        end
      endcase
    end
  end

  assign s1 = mode[1];
  assign s0 = mode[0];

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed self-checking bench for led_mode_sequencer with short debounce and dwell.
module tb_led_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_pause;
  logic       btn_faster;
  logic       btn_slower;
  logic       auto_en;
  logic       s1;
  logic       s0;
  logic       pause;
  logic [7:0] max;
  logic       auto_active;
  logic [1:0] mode_obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mode_obs = {s1, s0};

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_DWELL      (8),
    .MAX_STEP        (16),
    .MAX_INIT        (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .btn_pause   (btn_pause),
    .btn_faster  (btn_faster),
    .btn_slower  (btn_slower),
    .auto_en     (auto_en),
    .s1          (s1),
    .s0          (s0),
    .pause       (pause),
    .max         (max),
    .auto_active (auto_active)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] seq [4];
    logic [1:0] prev;
    int         exp_max;

    seq[0] = 2'b01;
    seq[1] = 2'b11;
    seq[2] = 2'b00;
    seq[3] = 2'b10;

    rst        = 1'b0;
    btn_mode   = 1'b0;
    btn_pause  = 1'b0;
    btn_faster = 1'b0;
    btn_slower = 1'b0;
    auto_en    = 1'b0;

    // Reset state
    tick(3);
    rst = 1'b1;
    check("rst_mode", 32'(mode_obs), 32'h2);
    check("rst_pause", 32'(pause), 32'h1);
    check("rst_max", 32'(max), 32'h0);
    check("rst_auto", 32'(auto_active), 32'h0);

    // Mode cycling, exact 7-cycle latency
    prev = 2'b10;
    for (int i = 0; i < 4; i++) begin
      btn_mode = 1'b1;
      tick(6);
      check("mode_early", 32'(mode_obs), 32'(prev));
      tick(1);
      check("mode_step", 32'(mode_obs), 32'(seq[i]));
      prev = seq[i];
      tick(3);
      btn_mode = 1'b0;
      tick(10);
      check("mode_release", 32'(mode_obs), 32'(prev));
    end

    // Bounce rejection: one advance, 7 cycles after final stable edge
    btn_mode = 1'b1; tick(2);
    btn_mode = 1'b0; tick(2);
    btn_mode = 1'b1; tick(2);
    btn_mode = 1'b0; tick(2);
    btn_mode = 1'b1;
    tick(6);
    check("bounce_early", 32'(mode_obs), 32'h2);
    tick(1);
    check("bounce_step", 32'(mode_obs), 32'h1);
    tick(3);
    btn_mode = 1'b0;
    tick(10);
    check("bounce_single", 32'(mode_obs), 32'h1);

    // Speed saturation upward
    exp_max = 0;
    for (int i = 0; i < 17; i++) begin
      btn_slower = 1'b1;
      tick(7);
      exp_max = (exp_max + 16 > 255) ? 255 : exp_max + 16;
      check("slower", 32'(max), 32'(exp_max));
      tick(3);
      btn_slower = 1'b0;
      tick(10);
    end
    check("slower_top", 32'(max), 32'd255);

    // Speed saturation downward
    for (int i = 0; i < 17; i++) begin
      btn_faster = 1'b1;
      tick(7);
      exp_max = (exp_max < 16) ? 0 : exp_max - 16;
      check("faster", 32'(max), 32'(exp_max));
      tick(3);
      btn_faster = 1'b0;
      tick(10);
    end
    check("faster_floor", 32'(max), 32'd0);

    // One slower press to 16, then faster+slower together leaves it alone
    btn_slower = 1'b1; tick(10); btn_slower = 1'b0; tick(10);
    check("pre_both", 32'(max), 32'd16);
    btn_faster = 1'b1;
    btn_slower = 1'b1;
    tick(7);
    check("both_same_cycle", 32'(max), 32'd16);
    tick(3);
    btn_faster = 1'b0;
    btn_slower = 1'b0;
    tick(10);
    for (int i = 0; i < 2; i++) begin
      btn_slower = 1'b1; tick(10); btn_slower = 1'b0; tick(10);
    end
    check("max_48", 32'(max), 32'd48);

    // Unpause before entering auto
    btn_pause = 1'b1;
    tick(7);
    check("unpause", 32'(pause), 32'h0);
    tick(3);
    btn_pause = 1'b0;
    tick(10);

    // Auto entry forces LEFT after 7 cycles
    auto_en = 1'b1;
    tick(6);
    check("auto_entry_early", 32'(auto_active), 32'h0);
    check("auto_entry_mode_early", 32'(mode_obs), 32'h1);
    tick(1);
    check("auto_entry", 32'(auto_active), 32'h1);
    check("auto_entry_mode", 32'(mode_obs), 32'h2);
    tick(7);
    check("dwell_hold_left", 32'(mode_obs), 32'h2);
    tick(1);
    check("dwell_toggle_right", 32'(mode_obs), 32'h1);

    // Pause lands when the dwell counter has reached its last value
    btn_pause = 1'b1;
    tick(7);
    check("auto_pause", 32'(pause), 32'h1);
    check("auto_pause_mode", 32'(mode_obs), 32'h1);
    tick(1);
    check("paused_no_toggle", 32'(mode_obs), 32'h1);
    tick(2);
    btn_pause = 1'b0;
    tick(10);
    check("paused_frozen", 32'(mode_obs), 32'h1);

    // Mode presses are ignored in auto
    btn_mode = 1'b1;
    tick(7);
    check("auto_mode_ignored", 32'(mode_obs), 32'h1);
    check("auto_still_active", 32'(auto_active), 32'h1);
    tick(3);
    btn_mode = 1'b0;
    tick(10);
    check("auto_mode_ignored_late", 32'(mode_obs), 32'h1);

    // Resume: frozen counter expires on the first unpaused cycle
    btn_pause = 1'b1;
    tick(7);
    check("resume_pause", 32'(pause), 32'h0);
    check("resume_mode_held", 32'(mode_obs), 32'h1);
    tick(1);
    check("resume_toggle_left", 32'(mode_obs), 32'h2);
    tick(7);
    check("resume_hold_left", 32'(mode_obs), 32'h2);
    tick(1);
    check("resume_toggle_right", 32'(mode_obs), 32'h1);

    // Reset mid-operation
    btn_pause = 1'b0;
    rst = 1'b0;
    tick(1);
    check("midrst_mode", 32'(mode_obs), 32'h2);
    check("midrst_pause", 32'(pause), 32'h1);
    check("midrst_max", 32'(max), 32'h0);
    check("midrst_auto", 32'(auto_active), 32'h0);
    rst = 1'b1;
    tick(6);
    check("reentry_early", 32'(auto_active), 32'h0);
    tick(1);
    check("reentry", 32'(auto_active), 32'h1);
    check("reentry_mode", 32'(mode_obs), 32'h2);
    tick(8);
    check("reentry_paused_hold", 32'(mode_obs), 32'h2);

    // Exit auto: mode retained
    auto_en = 1'b0;
    tick(6);
    check("exit_early", 32'(auto_active), 32'h1);
    tick(1);
    check("exit", 32'(auto_active), 32'h0);
    check("exit_mode_kept", 32'(mode_obs), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
